// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg
// Shared types and constants for the two-port KFSDRAM request arbiter.
//   arb_state_t          : arbiter FSM states
//   PORT_CPU, PORT_VIDEO : owner encodings (port 0 / port 1)
//   ADDR_W, NUM_W, DATA_W: KFSDRAM interface widths
package sdram_arbiter_pkg;

  localparam int ADDR_W = 25;
  localparam int NUM_W  = 10;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_VIDEO = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    TRANSFER,
    RELEASE,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick
// Winner selection for the two requesters plus the port-1 streak counter.
// Port 1 is preferred; after MAX_CONSECUTIVE port-1 grants made while port 0
// was waiting, port 0 gets the next grant.
//   clock, reset : SDRAM-domain clock, asynchronous active-high reset
//   req0, req1   : pending burst requests
//   take         : a grant is being made this cycle (updates the streak)
//   winner       : PORT_CPU or PORT_VIDEO, valid whenever a req is high
module sdram_arb_pick
  import sdram_arbiter_pkg::*;
#(
  parameter int MAX_CONSECUTIVE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic winner
);

  logic [3:0] streak;

  always_comb begin
    winner = PORT_CPU;
    if (req1 && (!req0 || streak != 4'(MAX_CONSECUTIVE)))
      winner = PORT_VIDEO;
  end

  // The streak only grows while port 0 is actually being held off; it can
  // never pass MAX_CONSECUTIVE because reaching it hands the next grant to
  // port 0, which clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (take) begin
      if (winner == PORT_VIDEO && req0)
        streak <= streak + 4'd1;
      else
        streak <= '0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares the single KFSDRAM burst request interface between the CPU port
// (port 0) and the video FIFO port (port 1). One whole burst is granted at a
// time; the request/flag/idle handshake is sequenced by a small FSM, write
// data is steered to the controller, read data is registered back, and the
// transferred words are counted to flag length mismatches.
// Ports:
//   clock, reset                 : SDRAM clock, async active-high reset
//   reqN, weN, addrN, numN       : burst request, direction, start, length
//   wdataN                       : current write word of port N
//   grantN                       : port N owns the controller
//   wstrobeN                     : port N write word consumed this cycle
//   rvalidN, rdata               : registered read word for port N
//   doneN, len_err               : burst-complete pulse, word-count mismatch
//   ctl_*                        : KFSDRAM request interface
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int MAX_CONSECUTIVE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [NUM_W-1:0]  num0,
  input  logic [NUM_W-1:0]  num1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic              wstrobe0,
  output logic              wstrobe1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              done0,
  output logic              done1,
  output logic              len_err,
  output logic [ADDR_W-1:0] ctl_address,
  output logic [NUM_W-1:0]  ctl_access_num,
  output logic [DATA_W-1:0] ctl_data_in,
  input  logic [DATA_W-1:0] ctl_data_out,
  output logic              ctl_write_request,
  output logic              ctl_read_request,
  input  logic              ctl_write_flag,
  input  logic              ctl_read_flag,
  input  logic              ctl_idle
);

  arb_state_t        state, next_state;
  logic              owner, owner_we;
  logic [ADDR_W-1:0] owner_addr;
  logic [NUM_W-1:0]  owner_num;
  logic [NUM_W-1:0]  word_cnt;
  logic              winner, take, flag, granted, rd_word;

  function automatic logic [NUM_W-1:0] sat_inc(input logic [NUM_W-1:0] v);
    return (v == '1) ? v : v + NUM_W'(1);
  endfunction

  assign take    = (state == IDLE) && ctl_idle && (req0 || req1);
  assign flag    = owner_we ? ctl_write_flag : ctl_read_flag;
  assign granted = (state == REQUEST) || (state == TRANSFER) || (state == RELEASE);
  assign rd_word = granted && !owner_we && ctl_read_flag;

  sdram_arb_pick #(
    .MAX_CONSECUTIVE(MAX_CONSECUTIVE)
  ) u_pick (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .take  (take),
    .winner(winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (take)     next_state = REQUEST;
      REQUEST:  if (flag)     next_state = TRANSFER;
      TRANSFER: if (!flag)    next_state = RELEASE;
      RELEASE:  next_state = ctl_idle ? IDLE : DRAIN;
      DRAIN:    if (ctl_idle) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // The first word can arrive on the cycle the flag first rises, while the
  // FSM is still in REQUEST, so that cycle is counted as well.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner      <= PORT_CPU;
      owner_we   <= 1'b0;
      owner_addr <= '0;
      owner_num  <= '0;
      word_cnt   <= '0;
    end else if (take) begin
      owner      <= winner;
      owner_we   <= winner ? we1 : we0;
      owner_addr <= winner ? addr1 : addr0;
      owner_num  <= winner ? num1 : num0;
      word_cnt   <= '0;
    end else if ((state == REQUEST || state == TRANSFER) && flag) begin
      word_cnt   <= sat_inc(word_cnt);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= rd_word && (owner == PORT_CPU);
      rvalid1 <= rd_word && (owner == PORT_VIDEO);
      if (rd_word) rdata <= ctl_data_out;
    end
  end

  always_comb begin
    ctl_write_request = 1'b0;
    ctl_read_request  = 1'b0;
    ctl_address       = '0;
    ctl_access_num    = '0;
    done0             = 1'b0;
    done1             = 1'b0;
    len_err           = 1'b0;
    case (state)
      REQUEST: begin
        ctl_write_request = owner_we;
        ctl_read_request  = !owner_we;
        ctl_address       = owner_addr;
        ctl_access_num    = owner_num;
      end
      TRANSFER: begin
        ctl_address       = owner_addr;
        ctl_access_num    = owner_num;
      end
      RELEASE: begin
        done0             = (owner == PORT_CPU);
        done1             = (owner == PORT_VIDEO);
        len_err           = (word_cnt != owner_num);
      end
      default: ;
    endcase
  end

  always_comb begin
    grant0      = granted && (owner == PORT_CPU);
    grant1      = granted && (owner == PORT_VIDEO);
    wstrobe0    = grant0 && owner_we && ctl_write_flag;
    wstrobe1    = grant1 && owner_we && ctl_write_flag;
    ctl_data_in = '0;
    if (granted && owner_we)
      ctl_data_in = (owner == PORT_VIDEO) ? wdata1 : wdata0;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed bench for sdram_arbiter: a cycle-by-cycle vector table for the
// single-port read, port-1 write burst and length-mismatch cases, followed by
// hand-written sequences for contention, controller-busy drain and reset
// in the middle of a burst. Inputs change on the falling edge; outputs are
// sampled 1 ns later.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam logic [24:0] A0 = 25'h0000123;
  localparam logic [24:0] A1 = 25'h00ABCDE;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [24:0] addr0, addr1;
  logic [9:0]  num0, num1;
  logic [15:0] wdata0, wdata1;
  logic        grant0, grant1, wstrobe0, wstrobe1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        done0, done1, len_err;
  logic [24:0] ctl_address;
  logic [9:0]  ctl_access_num;
  logic [15:0] ctl_data_in, ctl_data_out;
  logic        ctl_write_request, ctl_read_request;
  logic        ctl_write_flag, ctl_read_flag, ctl_idle;

  logic [10:0] act_ctl;
  assign act_ctl = {grant0, grant1, wstrobe0, wstrobe1, rvalid0, rvalid1,
                    done0, done1, len_err, ctl_write_request, ctl_read_request};

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sdram_arbiter #(.MAX_CONSECUTIVE(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .req0             (req0),
    .req1             (req1),
    .we0              (we0),
    .we1              (we1),
    .addr0            (addr0),
    .addr1            (addr1),
    .num0             (num0),
    .num1             (num1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .grant0           (grant0),
    .grant1           (grant1),
    .wstrobe0         (wstrobe0),
    .wstrobe1         (wstrobe1),
    .rvalid0          (rvalid0),
    .rvalid1          (rvalid1),
    .rdata            (rdata),
    .done0            (done0),
    .done1            (done1),
    .len_err          (len_err),
    .ctl_address      (ctl_address),
    .ctl_access_num   (ctl_access_num),
    .ctl_data_in      (ctl_data_in),
    .ctl_data_out     (ctl_data_out),
    .ctl_write_request(ctl_write_request),
    .ctl_read_request (ctl_read_request),
    .ctl_write_flag   (ctl_write_flag),
    .ctl_read_flag    (ctl_read_flag),
    .ctl_idle         (ctl_idle)
  );

  // in_ctl  = {req0, req1, we0, we1, write_flag, read_flag, ctl_idle}
  // exp_ctl = {grant0, grant1, wstrobe0, wstrobe1, rvalid0, rvalid1,
  //            done0, done1, len_err, write_request, read_request}
  typedef struct {
    logic [6:0]  in_ctl;
    logic [9:0]  n0;
    logic [15:0] dout;
    logic [15:0] wd1;
    logic [10:0] exp_ctl;
    logic [15:0] exp_rdata;
    logic [15:0] exp_din;
    logic [24:0] exp_addr;
    logic [9:0]  exp_num;
  } vec_t;

  vec_t vecs[23];
  int   order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output bit ok, output logic port);
    ok = 1'b0;
    port = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      #1;
      if (grant0 || grant1) begin
        ok = 1'b1;
        port = grant1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    logic port;

    // port-0 read of one word
    vecs[0]  = '{7'b0000001, 10'd1, 16'h0000, 16'h0000, 11'b00000000000, 16'h0000, 16'h0000, 25'h0, 10'd0};
    vecs[1]  = '{7'b1000001, 10'd1, 16'h0000, 16'h0000, 11'b00000000000, 16'h0000, 16'h0000, 25'h0, 10'd0};
    vecs[2]  = '{7'b1000000, 10'd1, 16'h0000, 16'h0000, 11'b10000000001, 16'h0000, 16'h0000, A0,    10'd1};
    vecs[3]  = '{7'b1000010, 10'd1, 16'hBEEF, 16'h0000, 11'b10000000001, 16'h0000, 16'h0000, A0,    10'd1};
    vecs[4]  = '{7'b1000000, 10'd1, 16'h0000, 16'h0000, 11'b10001000000, 16'hBEEF, 16'h0000, A0,    10'd1};
    vecs[5]  = '{7'b0000001, 10'd1, 16'h0000, 16'h0000, 11'b10000010000, 16'hBEEF, 16'h0000, 25'h0, 10'd0};
    vecs[6]  = '{7'b0000001, 10'd1, 16'h0000, 16'h0000, 11'b00000000000, 16'hBEEF, 16'h0000, 25'h0, 10'd0};
    // port-1 write of four words
    vecs[7]  = '{7'b0101001, 10'd1, 16'h0000, 16'h1111, 11'b00000000000, 16'hBEEF, 16'h0000, 25'h0, 10'd0};
    vecs[8]  = '{7'b0101000, 10'd1, 16'h0000, 16'h1111, 11'b01000000010, 16'hBEEF, 16'h1111, A1,    10'd4};
    vecs[9]  = '{7'b0101100, 10'd1, 16'h0000, 16'h1111, 11'b01010000010, 16'hBEEF, 16'h1111, A1,    10'd4};
    vecs[10] = '{7'b0101100, 10'd1, 16'h0000, 16'h2222, 11'b01010000000, 16'hBEEF, 16'h2222, A1,    10'd4};
    vecs[11] = '{7'b0101100, 10'd1, 16'h0000, 16'h3333, 11'b01010000000, 16'hBEEF, 16'h3333, A1,    10'd4};
    vecs[12] = '{7'b0101100, 10'd1, 16'h0000, 16'h4444, 11'b01010000000, 16'hBEEF, 16'h4444, A1,    10'd4};
    vecs[13] = '{7'b0101000, 10'd1, 16'h0000, 16'h4444, 11'b01000000000, 16'hBEEF, 16'h4444, A1,    10'd4};
    vecs[14] = '{7'b0101001, 10'd1, 16'h0000, 16'h4444, 11'b01000001000, 16'hBEEF, 16'h4444, 25'h0, 10'd0};
    vecs[15] = '{7'b0001001, 10'd1, 16'h0000, 16'h4444, 11'b00000000000, 16'hBEEF, 16'h0000, 25'h0, 10'd0};
    // port-0 read asking for 3 words but receiving 2
    vecs[16] = '{7'b1000001, 10'd3, 16'h0000, 16'h0000, 11'b00000000000, 16'hBEEF, 16'h0000, 25'h0, 10'd0};
    vecs[17] = '{7'b1000000, 10'd3, 16'h0000, 16'h0000, 11'b10000000001, 16'hBEEF, 16'h0000, A0,    10'd3};
    vecs[18] = '{7'b1000010, 10'd3, 16'h0001, 16'h0000, 11'b10000000001, 16'hBEEF, 16'h0000, A0,    10'd3};
    vecs[19] = '{7'b1000010, 10'd3, 16'h0002, 16'h0000, 11'b10001000000, 16'h0001, 16'h0000, A0,    10'd3};
    vecs[20] = '{7'b1000000, 10'd3, 16'h0000, 16'h0000, 11'b10001000000, 16'h0002, 16'h0000, A0,    10'd3};
    vecs[21] = '{7'b1000001, 10'd3, 16'h0000, 16'h0000, 11'b10000010100, 16'h0002, 16'h0000, 25'h0, 10'd0};
    vecs[22] = '{7'b0000001, 10'd3, 16'h0000, 16'h0000, 11'b00000000000, 16'h0002, 16'h0000, 25'h0, 10'd0};

    reset = 1'b1;
    {req0, req1, we0, we1, ctl_write_flag, ctl_read_flag} = '0;
    ctl_idle = 1'b1;
    addr0 = A0;
    addr1 = A1;
    num0 = 10'd1;
    num1 = 10'd4;
    wdata0 = 16'h0A0A;
    wdata1 = 16'h0000;
    ctl_data_out = 16'h0000;

    repeat (2) @(negedge clock);
    #1;
    chk("reset ctl outputs", act_ctl, 11'b0);
    chk("reset rdata", rdata, 16'h0);
    chk("reset ctl_address", ctl_address, 25'h0);
    chk("reset ctl_data_in", ctl_data_in, 16'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clock);
      {req0, req1, we0, we1, ctl_write_flag, ctl_read_flag, ctl_idle} = vecs[i].in_ctl;
      num0         = vecs[i].n0;
      ctl_data_out = vecs[i].dout;
      wdata1       = vecs[i].wd1;
      #1;
      chk($sformatf("row%0d ctl", i), act_ctl, vecs[i].exp_ctl);
      chk($sformatf("row%0d rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("row%0d data_in", i), ctl_data_in, vecs[i].exp_din);
      chk($sformatf("row%0d address", i), ctl_address, vecs[i].exp_addr);
      chk($sformatf("row%0d access_num", i), ctl_access_num, vecs[i].exp_num);
    end

    // contention: both ports request continuously, one-word reads
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    num0 = 10'd1; num1 = 10'd1; ctl_idle = 1'b1;
    ctl_write_flag = 1'b0; ctl_read_flag = 1'b0;
    for (int b = 0; b < 10; b++) begin
      wait_grant(ok, port);
      chk($sformatf("contention burst%0d winner", b), {ok, port}, {1'b1, order[b] == 1});
      if (!ok) break;
      ctl_read_flag = 1'b1;
      @(negedge clock);
      ctl_read_flag = 1'b0;
      @(negedge clock);
      #1;
      chk($sformatf("contention burst%0d done", b), {done0, done1, len_err},
          (order[b] == 1) ? 3'b010 : 3'b100);
    end
    req0 = 1'b0; req1 = 1'b0;

    // controller stays busy after the burst: DRAIN, then a delayed regrant
    @(negedge clock);
    req1 = 1'b1; we1 = 1'b0; num1 = 10'd1; ctl_idle = 1'b1;
    wait_grant(ok, port);
    chk("drain first grant", {ok, port}, 2'b11);
    ctl_idle = 1'b0;
    ctl_read_flag = 1'b1;
    ctl_data_out = 16'h5A5A;
    @(negedge clock);
    ctl_read_flag = 1'b0;
    #1;
    chk("drain rvalid1 rdata", {rvalid1, rdata}, {1'b1, 16'h5A5A});
    @(negedge clock);
    #1;
    chk("drain release done1", {done1, len_err}, 2'b10);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      chk($sformatf("drain quiet%0d", c), act_ctl, 11'b0);
    end
    ctl_idle = 1'b1;
    @(negedge clock);
    #1;
    chk("drain idle no grant", {grant0, grant1}, 2'b00);
    @(negedge clock);
    #1;
    chk("drain regrant", {grant1, ctl_read_request}, 2'b11);
    ctl_read_flag = 1'b1;
    @(negedge clock);
    ctl_read_flag = 1'b0;
    @(negedge clock);
    #1;
    chk("drain second done1", {done1, len_err}, 2'b10);
    req1 = 1'b0;

    // reset while a burst is transferring
    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; num0 = 10'd3;
    wait_grant(ok, port);
    chk("reset-test grant", {ok, port}, 2'b10);
    ctl_read_flag = 1'b1;
    ctl_data_out = 16'h1234;
    @(negedge clock);
    #1;
    chk("pre-reset transfer", {grant0, rvalid0, rdata}, {2'b11, 16'h1234});
    reset = 1'b1;
    #1;
    chk("mid-burst reset ctl", act_ctl, 11'b0);
    chk("mid-burst reset rdata", rdata, 16'h0);
    chk("mid-burst reset address", {ctl_address, ctl_access_num}, 35'h0);
    ctl_read_flag = 1'b0;
    req0 = 1'b0;
    num0 = 10'd1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      chk($sformatf("in-reset quiet%0d", c), act_ctl, 11'b0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post-reset no done", act_ctl, 11'b0);
    @(negedge clock);
    req0 = 1'b1;
    wait_grant(ok, port);
    chk("post-reset grant", {ok, port}, 2'b10);
    chk("post-reset request", {ctl_read_request, ctl_address, ctl_access_num}, {1'b1, A0, 10'd1});
    ctl_read_flag = 1'b1;
    @(negedge clock);
    ctl_read_flag = 1'b0;
    @(negedge clock);
    #1;
    chk("post-reset done0", {done0, len_err}, 2'b10);
    req0 = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single KFSDRAM burst-controller request interface between the CPU memory port (port 0) and the video/VRAM FIFO port (port 1). It sits in the SDRAM clock domain between the requesters and KFSDRAM. It grants one whole burst at a time and sequences the request/flag/idle handshake. It steers write data in and read data out, and counts transferred words to detect length mismatches. Port 1 is preferred, with a bounded starvation guard for port 0.

## Interface

Parameters:
- MAX_CONSECUTIVE, 4, maximum back-to-back port-1 grants while port 0 is waiting (range 1..15).

Ports:
- clock  in  1  SDRAM-domain clock
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  burst request; held high until the matching done pulse
- we0 / we1  in  1  1 = write burst, 0 = read burst; stable while req high
- addr0 / addr1  in  25  start word address
- num0 / num1  in  10  burst length in words
- wdata0 / wdata1  in  16  current write word
- grant0 / grant1  out  1  high while the port owns the controller
- wstrobe0 / wstrobe1  out  1  write word consumed this cycle; the requester advances wdata next cycle
- rvalid0 / rvalid1  out  1  rdata holds a valid read word
- rdata  out  16  registered read word (shared bus)
- done0 / done1  out  1  one-cycle burst-complete pulse
- len_err  out  1  one-cycle pulse together with done when words counted != num
- ctl_address  out  25  to KFSDRAM
- ctl_access_num  out  10  to KFSDRAM
- ctl_data_in  out  16  to KFSDRAM
- ctl_data_out  in  16  from KFSDRAM
- ctl_write_request / ctl_read_request  out  1  to KFSDRAM
- ctl_write_flag / ctl_read_flag  in  1  from KFSDRAM; high one cycle per transferred word
- ctl_idle  in  1  from KFSDRAM; controller can accept a new request

## Operation

State machine, one state register:
- IDLE
  - No request outputs are driven.
  - When ctl_idle and any req are high, pick a winner, latch owner, we, addr and num, and go to REQUEST.
- REQUEST
  - ctl_write_request = owner_we; ctl_read_request = ~owner_we.
  - When the relevant flag rises, go to TRANSFER.
- TRANSFER
  - Request outputs are low.
  - Count words (10-bit) on each cycle the flag is high.
  - When the flag falls, go to RELEASE.
- RELEASE
  - Pulse done for the owner, plus len_err if the count differs from the latched num.
  - If ctl_idle, go to IDLE; otherwise go to DRAIN.
- DRAIN
  - Wait for ctl_idle, then go to IDLE. No done pulse is issued here.

Arbitration:
- Only one requester → it wins.
- Both request → port 1 wins, unless the streak counter equals MAX_CONSECUTIVE, in which case port 0 wins.
- Streak counter (4-bit):
  - increments on each port-1 grant made while req0 is high;
  - clears on any port-0 grant, or when req0 is low at grant time.
- A req that drops after grant is ignored; the burst completes and done still pulses.

Datapath:
- ctl_address, ctl_access_num:
  - carry the latched values in REQUEST and TRANSFER;
  - are 0 in IDLE, RELEASE and DRAIN.
- ctl_data_in:
  - is the owner's wdata, combinational, while a write is granted;
  - is 0 otherwise.
- wstrobeN = grantN & owner_we & ctl_write_flag (combinational).
- rdata:
  - captures ctl_data_out when ctl_read_flag is high during an owned read;
  - rvalidN is registered from the same condition, so both appear one cycle after the flag.
- grantN is high from REQUEST through RELEASE inclusive.

Reset values:
- All outputs are 0.
- State is IDLE; owner, streak counter and word counter are 0.

## Timing

- Request sampled at edge N in IDLE → grant and ctl_*_request high after edge N.
- Burst-complete latency:
  - flag falls at edge M → RELEASE after edge M;
  - done and len_err are high for exactly that one cycle;
  - grant drops after edge M+1.
- Minimum request-to-request spacing: IDLE→REQUEST→TRANSFER→RELEASE→IDLE (four states), plus the burst itself.
- Simultaneous events:
  - a new req arriving in RELEASE is not granted until IDLE;
  - ctl_idle low in IDLE blocks all grants.
- Word counter saturates at 1023.
- num0 or num1 = 0 is forwarded unchanged; any counted words then raise len_err.
- Reset asserted mid-burst:
  - outputs clear immediately (asynchronous);
  - no done pulse is issued;
  - KFSDRAM shares the same reset.

## Structure

- Package sdram_arbiter_pkg holds:
  - the state enum arb_state_t (IDLE, REQUEST, TRANSFER, RELEASE, DRAIN);
  - port index constants PORT_CPU = 0 and PORT_VIDEO = 1;
  - widths ADDR_W = 25, NUM_W = 10, DATA_W = 16.
- One sub-module, sdram_arb_pick: combinational winner selection plus the registered streak counter.
- Everything else stays in sdram_arbiter.

## Test plan

- Port 0 read alone:
  - stimulus: addr0 = 0x00123, num0 = 1; the model raises read_flag for one cycle with data 0xBEEF;
  - response: rdata = 0xBEEF with rvalid0 one cycle later, then a single done0 and len_err = 0.
- Port 1 write burst:
  - stimulus: num1 = 4;
  - response: exactly 4 wstrobe1 pulses; ctl_data_in follows wdata1; done1 pulses once.
- Contention with MAX_CONSECUTIVE = 4:
  - stimulus: req0 and req1 held continuously;
  - response: grant order is 1,1,1,1,0,1,1,1,1,0.
- Length mismatch:
  - stimulus: num0 = 3; the model gives 2 flag cycles;
  - response: len_err pulses together with done0.
- Controller not idle:
  - stimulus: ctl_idle low after RELEASE;
  - response: the arbiter waits in DRAIN with no grants; req1 is granted one cycle after ctl_idle rises and IDLE is reached.
- Reset mid-burst:
  - stimulus: reset asserted in TRANSFER;
  - response: all outputs are 0 immediately and no done pulse occurs; after release, a new req0 is granted normally.
